// File: rtl/hangman_pkg.sv
// Shared constants for the hangman display path: glyph codes, renderer states,
// screen geometry and common field widths.
package hangman_pkg;

  // Glyph codes (letters share the guess-switch encoding)
  localparam logic [4:0] GLYPH_A     = 5'd0;
  localparam logic [4:0] GLYPH_Z     = 5'd25;
  localparam logic [4:0] GLYPH_BLANK = 5'd26;
  localparam logic [4:0] GLYPH_MASK  = 5'd31;

  // Screen geometry of the VGA adapter
  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  // Field widths
  localparam int unsigned SLOT_W   = 3;
  localparam int unsigned GLYPH_W  = 5;
  localparam int unsigned COLOUR_W = 3;
  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned FONT_W   = 5;

  // Renderer control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } rndr_state_e;

endpackage

// File: rtl/glyph_font_rom.sv
// 5x7 font ROM for letters A..Z. Row 0 is the top row; bit 4 is the leftmost
// pixel. Rows 7 and codes 26..31 read as zero.
module glyph_font_rom
  import hangman_pkg::*;
(
  input  logic [GLYPH_W-1:0] glyph,
  input  logic [CNT_W-1:0]   row,
  output logic [FONT_W-1:0]  bits
);

  logic [7*FONT_W-1:0] rows_c;

  // Whole 7-row bitmap for the selected letter, top row in the MSBs
  always_comb begin
    rows_c = '0;
    case (glyph)
      5'd0:  rows_c = {5'h0E, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11, 5'h11};
      5'd1:  rows_c = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h11, 5'h11, 5'h1E};
      5'd2:  rows_c = {5'h0E, 5'h11, 5'h10, 5'h10, 5'h10, 5'h11, 5'h0E};
      5'd3:  rows_c = {5'h1E, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h1E};
      5'd4:  rows_c = {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h1F};
      5'd5:  rows_c = {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h10};
      5'd6:  rows_c = {5'h0E, 5'h11, 5'h10, 5'h17, 5'h11, 5'h11, 5'h0F};
      5'd7:  rows_c = {5'h11, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11, 5'h11};
      5'd8:  rows_c = {5'h0E, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
      5'd9:  rows_c = {5'h07, 5'h02, 5'h02, 5'h02, 5'h02, 5'h12, 5'h0C};
      5'd10: rows_c = {5'h11, 5'h12, 5'h14, 5'h18, 5'h14, 5'h12, 5'h11};
      5'd11: rows_c = {5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h1F};
      5'd12: rows_c = {5'h11, 5'h1B, 5'h15, 5'h15, 5'h11, 5'h11, 5'h11};
      5'd13: rows_c = {5'h11, 5'h11, 5'h19, 5'h15, 5'h13, 5'h11, 5'h11};
      5'd14: rows_c = {5'h0E, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0E};
      5'd15: rows_c = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h10, 5'h10, 5'h10};
      5'd16: rows_c = {5'h0E, 5'h11, 5'h11, 5'h11, 5'h15, 5'h12, 5'h0D};
      5'd17: rows_c = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h14, 5'h12, 5'h11};
      5'd18: rows_c = {5'h0F, 5'h10, 5'h10, 5'h0E, 5'h01, 5'h01, 5'h1E};
      5'd19: rows_c = {5'h1F, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04};
      5'd20: rows_c = {5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0E};
      5'd21: rows_c = {5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0A, 5'h04};
      5'd22: rows_c = {5'h11, 5'h11, 5'h11, 5'h15, 5'h15, 5'h15, 5'h0A};
      5'd23: rows_c = {5'h11, 5'h11, 5'h0A, 5'h04, 5'h0A, 5'h11, 5'h11};
      5'd24: rows_c = {5'h11, 5'h11, 5'h0A, 5'h04, 5'h04, 5'h04, 5'h04};
      5'd25: rows_c = {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h1F};
      default: rows_c = '0;
    endcase
  end

  // Pick the requested row; row 7 is the blank descender row
  always_comb begin
    bits = '0;
    case (row)
      3'd0: bits = rows_c[34:30];
      3'd1: bits = rows_c[29:25];
      3'd2: bits = rows_c[24:20];
      3'd3: bits = rows_c[19:15];
      3'd4: bits = rows_c[14:10];
      3'd5: bits = rows_c[9:5];
      3'd6: bits = rows_c[4:0];
      default: bits = '0;
    endcase
  end

endmodule

// File: rtl/letter_tile_renderer.sv
// Sweeps the 8x8 tile of one word slot and writes it pixel by pixel to the
// VGA adapter. Optional build macro TILE_TRANSPARENT_EN: background pixels are
// swept without a write strobe so existing screen content shows through.
module letter_tile_renderer
  import hangman_pkg::*;
#(
  parameter int unsigned         NUM_SLOTS  = 5,
  parameter int unsigned         X_ORIGIN   = 42,
  parameter int unsigned         Y_ORIGIN   = 100,
  parameter int unsigned         TILE_PITCH = 10,
  parameter logic [COLOUR_W-1:0] BG_COLOUR  = 3'b000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [SLOT_W-1:0]   req_slot,
  input  logic [GLYPH_W-1:0]  req_glyph,
  input  logic [COLOUR_W-1:0] req_colour,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                done,
  output logic                err
);

  rndr_state_e         state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [GLYPH_W-1:0]  glyph_q, glyph_d;
  logic [COLOUR_W-1:0] fg_q, fg_d;
  logic [CNT_W-1:0]    row_q, row_d;
  logic [CNT_W-1:0]    col_q, col_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic                plot_q, plot_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                ready_q, ready_d;

  // Attributes of the pixel that would be presented after the next edge
  logic [SLOT_W-1:0]   nx_slot_c;
  logic [GLYPH_W-1:0]  nx_glyph_c;
  logic [COLOUR_W-1:0] nx_fg_c;
  logic [CNT_W-1:0]    nx_row_c;
  logic [CNT_W-1:0]    nx_col_c;
  logic [FONT_W-1:0]   font_bits_c;
  logic [7:0]          row_mask_c;
  logic                glyph_px_c;
  logic                pix_plot_c;
  logic [X_W-1:0]      pix_x_c;
  logic [Y_W-1:0]      pix_y_c;
  logic [COLOUR_W-1:0] pix_colour_c;
  logic                slot_oor_c;

  assign slot_oor_c = (32'(req_slot) >= NUM_SLOTS);

  // Next pixel comes from the request when idle, else from the latched job
  always_comb begin
    if (state_q == IDLE) begin
      nx_slot_c  = req_slot;
      nx_glyph_c = req_glyph;
      nx_fg_c    = req_colour;
      nx_row_c   = '0;
      nx_col_c   = '0;
    end else begin
      nx_slot_c  = slot_q;
      nx_glyph_c = glyph_q;
      nx_fg_c    = fg_q;
      {nx_row_c, nx_col_c} = 6'({row_q, col_q} + 6'd1);
    end
  end

  glyph_font_rom u_font (
    .glyph (nx_glyph_c),
    .row   (nx_row_c),
    .bits  (font_bits_c)
  );

  // Glyph coverage of the next row indexed by column; letters occupy cols 1..5
  always_comb begin
    row_mask_c = {2'b00, font_bits_c[0], font_bits_c[1], font_bits_c[2],
                  font_bits_c[3], font_bits_c[4], 1'b0};
    if (nx_glyph_c == GLYPH_MASK && nx_row_c == 3'd7) begin
      row_mask_c = 8'h7F;
    end
  end

  // Address, colour and strobe of the next pixel
  always_comb begin
    glyph_px_c   = row_mask_c[nx_col_c];
    pix_x_c      = X_W'(X_ORIGIN + 32'(nx_slot_c) * TILE_PITCH + 32'(nx_col_c));
    pix_y_c      = Y_W'(Y_ORIGIN + 32'(nx_row_c));
    pix_colour_c = glyph_px_c ? nx_fg_c : BG_COLOUR;
`ifdef TILE_TRANSPARENT_EN
    pix_plot_c   = glyph_px_c;
`else
    pix_plot_c   = 1'b1;
`endif
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    glyph_d  = glyph_q;
    fg_d     = fg_q;
    row_d    = row_q;
    col_d    = col_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          slot_d  = req_slot;
          glyph_d = req_glyph;
          fg_d    = req_colour;
          if (slot_oor_c) begin
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = DRAW;
            row_d   = '0;
            col_d   = '0;
            plot_d  = pix_plot_c;
            if (pix_plot_c) begin
              x_d      = pix_x_c;
              y_d      = pix_y_c;
              colour_d = pix_colour_c;
            end
          end
        end
      end
      DRAW: begin
        if (row_q == 3'd7 && col_q == 3'd7) begin
          state_d = DONE;
          done_d  = 1'b1;
          row_d   = '0;
          col_d   = '0;
        end else begin
          row_d  = nx_row_c;
          col_d  = nx_col_c;
          plot_d = pix_plot_c;
          if (pix_plot_c) begin
            x_d      = pix_x_c;
            y_d      = pix_y_c;
            colour_d = pix_colour_c;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      slot_q   <= '0;
      glyph_q  <= '0;
      fg_q     <= '0;
      row_q    <= '0;
      col_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      glyph_q  <= glyph_d;
      fg_q     <= fg_d;
      row_q    <= row_d;
      col_q    <= col_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
    end
  end

  assign req_ready = ready_q;
  assign x         = x_q;
  assign y         = y_q;
  assign colour    = colour_q;
  assign plot      = plot_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_letter_tile_renderer.sv
// Bench for letter_tile_renderer: directed and random draw requests compared
// cycle by cycle against a pixel-level model of the tile. Honours
// TILE_TRANSPARENT_EN when defined.
module tb_letter_tile_renderer;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_slot;
  logic [4:0] req_glyph;
  logic [2:0] req_colour;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       done;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;

  // Last pixel the model expects to have been written (outputs hold it)
  int last_x = 0;
  int last_y = 0;
  int last_c = 0;

  // Independent copy of the 5x7 letter shapes, top row first, bit 4 = left
  logic [4:0] font [0:25][0:6] = '{
    '{5'h0E,5'h11,5'h11,5'h1F,5'h11,5'h11,5'h11}, '{5'h1E,5'h11,5'h11,5'h1E,5'h11,5'h11,5'h1E},
    '{5'h0E,5'h11,5'h10,5'h10,5'h10,5'h11,5'h0E}, '{5'h1E,5'h11,5'h11,5'h11,5'h11,5'h11,5'h1E},
    '{5'h1F,5'h10,5'h10,5'h1E,5'h10,5'h10,5'h1F}, '{5'h1F,5'h10,5'h10,5'h1E,5'h10,5'h10,5'h10},
    '{5'h0E,5'h11,5'h10,5'h17,5'h11,5'h11,5'h0F}, '{5'h11,5'h11,5'h11,5'h1F,5'h11,5'h11,5'h11},
    '{5'h0E,5'h04,5'h04,5'h04,5'h04,5'h04,5'h0E}, '{5'h07,5'h02,5'h02,5'h02,5'h02,5'h12,5'h0C},
    '{5'h11,5'h12,5'h14,5'h18,5'h14,5'h12,5'h11}, '{5'h10,5'h10,5'h10,5'h10,5'h10,5'h10,5'h1F},
    '{5'h11,5'h1B,5'h15,5'h15,5'h11,5'h11,5'h11}, '{5'h11,5'h11,5'h19,5'h15,5'h13,5'h11,5'h11},
    '{5'h0E,5'h11,5'h11,5'h11,5'h11,5'h11,5'h0E}, '{5'h1E,5'h11,5'h11,5'h1E,5'h10,5'h10,5'h10},
    '{5'h0E,5'h11,5'h11,5'h11,5'h15,5'h12,5'h0D}, '{5'h1E,5'h11,5'h11,5'h1E,5'h14,5'h12,5'h11},
    '{5'h0F,5'h10,5'h10,5'h0E,5'h01,5'h01,5'h1E}, '{5'h1F,5'h04,5'h04,5'h04,5'h04,5'h04,5'h04},
    '{5'h11,5'h11,5'h11,5'h11,5'h11,5'h11,5'h0E}, '{5'h11,5'h11,5'h11,5'h11,5'h11,5'h0A,5'h04},
    '{5'h11,5'h11,5'h11,5'h15,5'h15,5'h15,5'h0A}, '{5'h11,5'h11,5'h0A,5'h04,5'h0A,5'h11,5'h11},
    '{5'h11,5'h11,5'h0A,5'h04,5'h04,5'h04,5'h04}, '{5'h1F,5'h01,5'h02,5'h04,5'h08,5'h10,5'h1F}
  };

  letter_tile_renderer dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_slot   (req_slot),
    .req_glyph  (req_glyph),
    .req_colour (req_colour),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Is (row,col) of the tile part of the glyph shape?
  function automatic bit is_glyph_px(input int glyph, input int row, input int col);
    logic [4:0] bits;
    if (glyph <= 25) begin
      if (row > 6 || col < 1 || col > 5) return 1'b0;
      bits = font[glyph][row];
      return bits[5 - col];
    end
    if (glyph == 31) return (row == 7 && col <= 6);
    return 1'b0;
  endfunction

  // Number of foreground pixels in a glyph, straight from the shape table
  function automatic int glyph_pop(input int glyph);
    int n = 0;
    if (glyph <= 25) begin
      for (int r = 0; r < 7; r++) n += $countones(font[glyph][r]);
    end else if (glyph == 31) begin
      n = 7;
    end
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from a cycle where the renderer should be idle and check
  // every following cycle. abort_at >= 0 returns while sampling that pixel.
  task automatic run_req(input int slot, input int glyph, input int fg,
                         input bit noisy, input int abort_at);
    int  seen_fg;
    bit  eplot;
    int  ex, ey, ec;
    check("ready_idle", req_ready, 1);
    req_valid  = 1'b1;
    req_slot   = 3'(slot);
    req_glyph  = 5'(glyph);
    req_colour = 3'(fg);
    tick();
    req_valid = 1'b0;
    if (slot >= 5) begin
      check("oor_plot", plot, 0);
      check("oor_done", done, 1);
      check("oor_err", err, 1);
      check("oor_ready_busy", req_ready, 0);
      tick();
      check("oor_ready_back", req_ready, 1);
      check("oor_done_low", done, 0);
      check("oor_err_low", err, 0);
      check("oor_x_hold", x, last_x);
      return;
    end
    seen_fg = 0;
    for (int k = 0; k < 64; k++) begin
      int row = k / 8;
      int col = k % 8;
      bit g = is_glyph_px(glyph, row, col);
`ifdef TILE_TRANSPARENT_EN
      eplot = g;
`else
      eplot = 1'b1;
`endif
      if (eplot) begin
        last_x = (42 + slot * 10 + col) % 256;
        last_y = (100 + row) % 128;
        last_c = g ? fg : 0;
      end
      ex = last_x; ey = last_y; ec = last_c;
      check("plot", plot, eplot);
      check("x", x, ex);
      check("y", y, ey);
      check("colour", colour, ec);
      check("done_busy", done, 0);
      check("err_busy", err, 0);
      check("ready_busy", req_ready, 0);
      if (plot === 1'b1 && colour == 3'(fg)) seen_fg++;
      if (k == abort_at) return;
      if (noisy) begin
        req_valid  = 1'b1;
        req_slot   = 3'($urandom_range(0, 7));
        req_glyph  = 5'($urandom);
        req_colour = 3'($urandom);
      end
      tick();
    end
    req_valid = 1'b0;
    check("done_pulse", done, 1);
    check("err_clear", err, 0);
    check("plot_after", plot, 0);
    check("ready_in_done", req_ready, 0);
    if (fg != 0) check("glyph_count", seen_fg, glyph_pop(glyph));
    tick();
    check("ready_back", req_ready, 1);
    check("done_once", done, 0);
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_slot   = '0;
    req_glyph  = '0;
    req_colour = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", req_ready, 1);
    check("rst_plot", plot, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_colour", colour, 0);
    reset = 1'b0;
    tick();

    // Letter S in slot 0, green
    run_req(0, 18, 3'b010, 1'b0, -1);
    // Mask underscore in slot 3, white, issued back to back in the ready cycle
    run_req(3, 31, 3'b111, 1'b0, -1);
    // Out-of-range slot
    run_req(5, 4, 3'b001, 1'b0, -1);
    // Interfering requests during a draw
    run_req(2, 7, 3'b100, 1'b1, -1);
    // Blank glyph and letter A in slot 1
    run_req(4, 27, 3'b011, 1'b0, -1);
    run_req(1, 0, 3'b101, 1'b0, -1);

    // Reset in cycle 30 of a draw: outputs drop without a clock edge
    run_req(1, 22, 3'b110, 1'b0, 29);
    #2 reset = 1'b1;
    #1;
    check("arst_plot", plot, 0);
    check("arst_done", done, 0);
    check("arst_err", err, 0);
    check("arst_ready", req_ready, 1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    last_x = 0; last_y = 0; last_c = 0;
    check("arst_x", x, 0);
    tick();
    run_req(4, 25, 3'b001, 1'b0, -1);

    // Random requests, including out-of-range slots and non-letter codes
    for (int i = 0; i < 14; i++) begin
      run_req(int'($urandom_range(0, 6)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 7)), 1'($urandom), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
